// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiplier sequencer.
package booth_pkg;

  localparam int WIDTH_DEFAULT = 4;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/booth_step_counter.sv
// Booth iteration counter: cleared on load, bumped once per shift, flags the final iteration.
module booth_step_counter #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Sampled during SHIFT: the shift now in progress is the last one.
  assign last = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/booth_sequencer.sv
// Sequencer for the Booth multiplier datapath: operand handshake, strobe generation
// across WIDTH iterations and a single-entry result buffer.
module booth_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the producer holds its data while valid is 1 and ready is 0.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  input  logic               Q0,
  input  logic               Q1,
  input  logic [2*WIDTH-1:0] prod,
  output logic               LoadA,
  output logic               LoadB,
  output logic               LoadAdd,
  output logic               Shift,
  output logic               SEL,
  output logic               rs,
  output logic [WIDTH-1:0]   A,
  output logic [WIDTH-1:0]   B,
  output logic [2:0]         dbg_state
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               last_iter;

  booth_step_counter #(.WIDTH(WIDTH)) u_step_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == LOAD),
    .inc  (state_q == SHIFT),
    .last (last_iter)
  );

  assign in_ready  = (state_q == IDLE) && !out_valid_q;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign A         = a_q;
  assign B         = b_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    LoadA       = 1'b0;
    LoadB       = 1'b0;
    LoadAdd     = 1'b0;
    Shift       = 1'b0;
    SEL         = SEL_ADD;
    rs          = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a_in;
          b_d     = b_in;
          state_d = LOAD;
        end
      end
      LOAD: begin
        LoadA   = 1'b1;
        LoadB   = 1'b1;
        rs      = 1'b1;
        state_d = EVAL;
      end
      EVAL: begin
        // {Q0,Q1}: 10 starts a run of ones (subtract), 01 ends one (add).
        unique case ({Q0, Q1})
          2'b10: begin
            LoadAdd = 1'b1;
            SEL     = SEL_SUB;
          end
          2'b01: begin
            LoadAdd = 1'b1;
            SEL     = SEL_ADD;
          end
          default: ;
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        Shift   = 1'b1;
        state_d = last_iter ? DONE : EVAL;
      end
      DONE: begin
        result_d    = prod;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer: behavioural Booth datapath, signed-product scoreboard,
// per-operation strobe accounting, backpressure and mid-operation reset.
module tb_booth_sequencer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           busy;
  logic           Q0, Q1;
  logic [2*W-1:0] prod;
  logic           LoadA, LoadB, LoadAdd, Shift, SEL, rs;
  logic [W-1:0]   A, B;
  logic [2:0]     dbg_state;

  booth_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy),
    .Q0(Q0), .Q1(Q1), .prod(prod),
    .LoadA(LoadA), .LoadB(LoadB), .LoadAdd(LoadAdd), .Shift(Shift), .SEL(SEL), .rs(rs),
    .A(A), .B(B), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath; accumulator carries one guard bit so -8*-8 is exact.
  logic signed [W:0] hq = '0;
  logic [W-1:0]      lq = '0;
  logic [W-1:0]      m  = '0;
  logic              q1 = 1'b0;
  always @(posedge clk) begin
    if (LoadA) m <= A;
    if (LoadB) lq <= B;
    if (rs) begin
      hq <= '0;
      q1 <= 1'b0;
    end
    if (LoadAdd) hq <= SEL ? hq - $signed({m[W-1], m}) : hq + $signed({m[W-1], m});
    if (Shift) {hq, lq, q1} <= {hq[W], hq, lq};
  end
  assign Q0   = lq[0];
  assign Q1   = q1;
  assign prod = {hq[W-1:0], lq};

  // scoreboard state
  logic [2*W-1:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib, p;
    ia = int'($signed(a));
    ib = int'($signed(b));
    p  = ia * ib;
    return p[2*W-1:0];
  endfunction

  // Booth recoding: one add/sub per bit where b[i] differs from b[i-1] (b[-1]=0).
  function automatic int booth_ops(input logic [W-1:0] b, input bit sub_only);
    int n;
    logic prev;
    n = 0;
    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (b[i] != prev && (!sub_only || b[i])) n++;
      prev = b[i];
    end
    return n;
  endfunction

  // monitor
  bit             in_op = 0;
  bit             held = 0;
  bit             stray = 0;
  bit             both_seen = 0;
  logic [2*W-1:0] held_res;
  logic [W-1:0]   cur_b;
  int             acc_cyc, n_load, n_shift, n_add, n_sub;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      in_op = 0;
      held  = 0;
      stray = 0;
    end else begin
      if (in_op) begin
        if (LoadA && LoadB && rs) n_load++;
        if (Shift) n_shift++;
        if (LoadAdd) begin
          n_add++;
          if (SEL) n_sub++;
        end
        if (Shift && LoadAdd) both_seen = 1;
        if (out_valid) begin
          check("latency", cyc - acc_cyc, 2 * W + 2);
          check("load_pulses", n_load, 1);
          check("shift_pulses", n_shift, W);
          check("loadadd_pulses", n_add, booth_ops(cur_b, 0));
          check("sub_pulses", n_sub, booth_ops(cur_b, 1));
          check("shift_loadadd_excl", both_seen, 0);
          in_op = 0;
        end
      end else if (LoadA || LoadB || LoadAdd || Shift || rs || SEL) begin
        stray = 1;
      end
      if (out_valid) begin
        if (held) check("result_stable", result, held_res);
        else begin
          held     = 1;
          held_res = result;
        end
        if (out_ready) begin
          if (exp_q.size() == 0) check("unexpected_result", 1, 0);
          else check("result", result, exp_q.pop_front());
          check("idle_strobes", stray, 0);
          held  = 0;
          stray = 0;
        end
      end
      if (in_valid && in_ready) begin
        if (in_op) check("accept_while_busy", 1, 0);
        exp_q.push_back(ref_prod(a_in, b_in));
        in_op     = 1;
        acc_cyc   = cyc + 1;
        cur_b     = b_in;
        n_load    = 0;
        n_shift   = 0;
        n_add     = 0;
        n_sub     = 0;
        both_seen = 0;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit done;
    done = 0;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    for (int i = 0; i < 200 && !done; i++) begin
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    a_in = W'($urandom);
    b_in = W'($urandom);
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !in_op && !out_valid) done = 1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  bit rand_bp = 0;
  always @(posedge clk) begin
    if (rand_bp) begin
      #2;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [W-1:0] dir_a[6] = '{4'h3, 4'h8, 4'h8, 4'h7, 4'h0, 4'h5};
  logic [W-1:0] dir_b[6] = '{4'hE, 4'h7, 4'h8, 4'h7, 4'hB, 4'h0};

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_strobes", {LoadA, LoadB, LoadAdd, Shift, SEL, rs}, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_busy", busy, 0);
    @(posedge clk);
    #1;

    // directed operands: 3*-2, -8*7, -8*-8, 7*7, 0*-5, 5*0
    for (int i = 0; i < 6; i++) begin
      send(dir_a[i], dir_b[i]);
      wait_idle();
    end

    // randomized back-to-back traffic with random consumer stalls
    rand_bp = 1;
    for (int i = 0; i < 40; i++) send(W'($urandom), W'($urandom));
    rand_bp = 0;
    #3 out_ready = 1'b1;
    wait_idle();

    // backpressure: 2*5 held for 5 cycles while a second operand is offered
    out_ready = 1'b0;
    send(4'h2, 4'h5);
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a_in = 4'h1;
      b_in = 4'h1;
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_result", result, 8'h0A);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    wait_idle();

    // reset during the second SHIFT, then a clean 2*3
    begin
      int n;
      n = 0;
      in_valid = 1'b1;
      a_in = 4'h5;
      b_in = 4'h3;
      for (int i = 0; i < 50 && n < 2; i++) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (Shift) n++;
      end
      check("mid_reset_reached_shift2", n, 2);
      rst = 1'b0;
      #1;
      check("mid_reset_strobes", {LoadA, LoadB, LoadAdd, Shift, SEL, rs}, 0);
      check("mid_reset_busy", busy, 0);
      check("mid_reset_out_valid", out_valid, 0);
      check("mid_reset_result", result, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      send(4'h2, 4'h3);
      for (int i = 0; i < 50 && !out_valid; i++) begin
        @(posedge clk);
        #1;
      end
      check("post_reset_result", result, 8'h06);
      wait_idle();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
